input_buffer_ctrl: RTL and testbench
====================================

# input_buffer_ctrl

Sequencing controller for the input buffer's dual-port vector RAM. It accepts the per-cycle `enqueue`/`eof_in` strobes from the trace front-end and drives the RAM write port (head) and read port (tail). It tracks occupancy, drops or counts overflow, and issues reads only when downstream is ready. It re-aligns `valid_out`/`eof_out` with the RAM read latency so the next stage receives correctly qualified vectors.

## Interface
- `IB_DEPTH`, 4, number of vector slots; power of two, ≥2
- `RAM_LATENCY`, 1, cycles from `rd_en` to RAM data valid; range 1..4
- `CNT_WIDTH`, 16, width of the overflow drop counter
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-high
- `enqueue`  in  1  a vector is present on the RAM write data this cycle
- `eof_in`  in  1  end-of-frame flag accompanying `enqueue`
- `ready_in`  in  1  downstream accepts a vector `RAM_LATENCY` cycles from now
- `flush`  in  1  single-cycle request to discard all buffered vectors
- `wr_en`  out  1  RAM port A write enable
- `wr_addr`  out  $clog2(IB_DEPTH)  RAM port A address (head)
- `rd_en`  out  1  RAM port B read enable
- `rd_addr`  out  $clog2(IB_DEPTH)  RAM port B address (tail)
- `valid_out`  out  1  RAM `q_b` holds a valid vector this cycle
- `eof_out`  out  1  EOF flag of the vector on `q_b`, qualified by `valid_out`
- `full`  out  1  occupancy == IB_DEPTH
- `empty`  out  1  occupancy == 0
- `occupancy`  out  $clog2(IB_DEPTH)+1  stored vector count
- `drop_count`  out  CNT_WIDTH  overflow drops; present only with `IB_DROP_COUNT_EN`

## Operation
- Pointers `head` and `tail` are $clog2(IB_DEPTH) bits wide and wrap naturally from IB_DEPTH-1 to 0. `occupancy` is a separate register.
- Write path (combinational):
  - `wr_en = enqueue & ~full & (state==RUN)`.
  - `wr_addr = head`.
  - On `wr_en`, `head` increments and `eof_in` is stored in internal flag array `eof_mem[head]`.
- Read path (combinational):
  - `rd_en = ~empty & ready_in & (state==RUN)`.
  - `rd_addr = tail`.
  - On `rd_en`, `tail` increments.
- Occupancy: next = occupancy + wr_en − rd_en. Simultaneous write and read leaves occupancy unchanged.
- `full`, `empty` and `occupancy` are decoded from the registered occupancy. Consequences:
  - Enqueue while full is dropped, even when a read happens in the same cycle.
  - Enqueue while empty is not bypassed. The earliest read of that vector is the next cycle.
- Output alignment: `rd_en` and `eof_mem[tail]` enter a RAM_LATENCY-deep shift pipeline. Its tail drives `valid_out`/`eof_out`. In-flight reads are never cancelled by `ready_in` falling.
- State machine, 2 states:
  - RUN: normal operation. `flush` → FLUSH, with a drain counter loaded with RAM_LATENCY.
  - FLUSH: `wr_en`=`rd_en`=0 and `enqueue` is ignored (not counted as a drop). Pipeline contents still drain to `valid_out`. The drain counter decrements each cycle. At 0, `head`, `tail` and `occupancy` clear and the state returns to RUN.
  - `flush` asserted while in FLUSH is ignored.
- Reset (asynchronous):
  - state = RUN; `head`, `tail`, `occupancy` = 0; pipeline cleared.
  - `valid_out`=0, `eof_out`=0, `full`=0, `empty`=1, `occupancy`=0, `drop_count`=0.
  - `wr_en`/`rd_en` = 0, since the buffer is empty and nothing is enqueued.
  - Reset mid-operation discards all contents and in-flight reads immediately.

## Timing
- Enqueue at cycle t: `occupancy` updates at t+1, earliest `rd_en` is at t+1, and `valid_out` asserts at t+1+RAM_LATENCY.
- Sustained throughput: one write and one read per cycle.
- `flush` at cycle t:
  - FLUSH occupies cycles t+1 .. t+1+RAM_LATENCY−1.
  - RUN resumes with `empty`=1 at t+1+RAM_LATENCY.
  - A `rd_en` issued at cycle t still yields `valid_out` at t+RAM_LATENCY.
- All outputs except `wr_en`, `rd_en`, `wr_addr` and `rd_addr` are registered.

## Configuration
- Macro: `IB_DROP_COUNT_EN`.
- Defined: `drop_count` port exists. It increments by 1 on each cycle with `enqueue & full & (state==RUN)` and saturates at 2^CNT_WIDTH−1. It clears only on `rst`; flush does not clear it.
- Undefined: port and counter are absent. Overflow enqueues are silently dropped; behaviour is otherwise identical.

## Test plan
All scenarios use IB_DEPTH=4, RAM_LATENCY=1.
- Fill and drain: 4 enqueues with `ready_in`=0 give `full`=1 and `occupancy`=4. A 5th enqueue gives `wr_en`=0 and `drop_count`=1. Raising `ready_in` gives `rd_addr` 0,1,2,3 and 4 `valid_out` pulses, each one cycle after its `rd_en`, then `empty`=1.
- Streaming wrap: enqueue every cycle with `ready_in`=1 for 10 cycles. `occupancy` stays at most 1, `wr_addr` wraps 3→0, exactly 10 `valid_out` pulses appear, and no drops occur.
- EOF ordering: enqueue vectors with `eof_in` pattern 0,0,1,0, then drain. `eof_out` is 1 only on the 3rd `valid_out`.
- Full with simultaneous read: with `occupancy`=4, apply `enqueue`=1 and `ready_in`=1 together. Result: `rd_en`=1, `wr_en`=0, drop counted, `occupancy`=3 next cycle.
- Flush: `occupancy`=3 with `rd_en` active at the flush cycle. The in-flight vector gives `valid_out`=1 one cycle later. An enqueue during FLUSH is ignored with `drop_count` unchanged. Afterwards `empty`=1 and `head`=`tail`=0.
- Async reset mid-stream: assert `rst` between clock edges with `occupancy`=2. All outputs take their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/input_buffer_ctrl.sv
// Head/tail sequencer for the input buffer vector RAM with read-latency alignment.
// Optional overflow drop counter enabled by defining IB_DROP_COUNT_EN.
module input_buffer_ctrl #(
  parameter int IB_DEPTH    = 4,
  parameter int RAM_LATENCY = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enqueue,
  input  logic                         eof_in,
  input  logic                         ready_in,
  input  logic                         flush,
  output logic                         wr_en,
  output logic [$clog2(IB_DEPTH)-1:0]  wr_addr,
  output logic                         rd_en,
  output logic [$clog2(IB_DEPTH)-1:0]  rd_addr,
  output logic                         valid_out,
  output logic                         eof_out,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(IB_DEPTH):0]    occupancy
`ifdef IB_DROP_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0]         drop_count
`endif
);

  localparam int AW = $clog2(IB_DEPTH);

  if (IB_DEPTH < 2 || RAM_LATENCY < 1 ||
      RAM_LATENCY > 4 || CNT_WIDTH < 1) begin : g_bad_param
    $error("input_buffer_ctrl: bad parameter");
  end

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          head_q, head_d;
  logic [AW-1:0]          tail_q, tail_d;
  logic [AW:0]            occ_q, occ_d;
  logic [IB_DEPTH-1:0]    eof_mem_q, eof_mem_d;
  logic [RAM_LATENCY-1:0] vpipe_q, vpipe_d;
  logic [RAM_LATENCY-1:0] epipe_q, epipe_d;
  logic [2:0]             drain_q, drain_d;
  logic                   run;

  assign run       = (state_q == RUN);
  assign full      = (occ_q == (AW+1)'(IB_DEPTH));
  assign empty     = (occ_q == '0);
  assign occupancy = occ_q;

  assign wr_en   = enqueue & ~full & run;
  assign wr_addr = head_q;
  assign rd_en   = ~empty & ready_in & run;
  assign rd_addr = tail_q;

  assign valid_out = vpipe_q[RAM_LATENCY-1];
  assign eof_out   = epipe_q[RAM_LATENCY-1];

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    occ_d     = occ_q;
    eof_mem_d = eof_mem_q;
    drain_d   = drain_q;
    vpipe_d   = '0;
    epipe_d   = '0;

    if (wr_en) begin
      head_d            = head_q + 1'b1;
      eof_mem_d[head_q] = eof_in;
    end
    if (rd_en) tail_d = tail_q + 1'b1;

    unique case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    // Reads already issued keep draining through the pipe in every state
    vpipe_d[0] = rd_en;
    epipe_d[0] = rd_en & eof_mem_q[tail_q];
    for (int i = 1; i < RAM_LATENCY; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
      epipe_d[i] = epipe_q[i-1];
    end

    unique case (state_q)
      RUN: begin
        if (flush) begin
          state_d = FLUSH;
          drain_d = 3'(RAM_LATENCY);
        end
      end
      FLUSH: begin
        drain_d = drain_q - 1'b1;
        if (drain_q <= 3'd1) begin
          state_d = RUN;
          drain_d = '0;
          head_d  = '0;
          tail_d  = '0;
          occ_d   = '0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      head_q    <= '0;
      tail_q    <= '0;
      occ_q     <= '0;
      eof_mem_q <= '0;
      drain_q   <= '0;
      vpipe_q   <= '0;
      epipe_q   <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      occ_q     <= occ_d;
      eof_mem_q <= eof_mem_d;
      drain_q   <= drain_d;
      vpipe_q   <= vpipe_d;
      epipe_q   <= epipe_d;
    end
  end

`ifdef IB_DROP_COUNT_EN
  logic [CNT_WIDTH-1:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (enqueue && full && run && (drop_q != '1))
      drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_input_buffer_ctrl.sv
// Directed bench for input_buffer_ctrl (IB_DEPTH=4, RAM_LATENCY=1).
// Drop counter checks are active when IB_DROP_COUNT_EN is defined.
module tb_input_buffer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enqueue, eof_in, ready_in, flush;
  logic       wr_en, rd_en, valid_out, eof_out, full, empty;
  logic [1:0] wr_addr, rd_addr;
  logic [2:0] occupancy;
`ifdef IB_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int vcount;
  int occ_max;

  input_buffer_ctrl #(
    .IB_DEPTH   (4),
    .RAM_LATENCY(1),
    .CNT_WIDTH  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enqueue   (enqueue),
    .eof_in    (eof_in),
    .ready_in  (ready_in),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .valid_out (valid_out),
    .eof_out   (eof_out),
    .full      (full),
    .empty     (empty),
    .occupancy (occupancy)
`ifdef IB_DROP_COUNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_drop(input string tag, input int exp);
`ifdef IB_DROP_COUNT_EN
    chk(tag, int'(drop_count), exp);
`endif
  endtask

  // Inputs change 1 ns after the rising edge; checks follow 1 ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; enqueue = 0; eof_in = 0; ready_in = 0; flush = 0;
    #2;
    chk("rst_valid", valid_out, 0);
    chk("rst_eof", eof_out, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_occ", occupancy, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_en", rd_en, 0);
    chk_drop("rst_drop", 0);
    tick();
    rst = 1'b0;

    // Fill with eof pattern 0,0,1,0 while downstream stalls
    for (int i = 0; i < 4; i++) begin
      enqueue = 1; eof_in = (i == 2); ready_in = 0;
      #1;
      chk($sformatf("fill_wr_en%0d", i), wr_en, 1);
      chk($sformatf("fill_wr_addr%0d", i), wr_addr, i);
      chk($sformatf("fill_rd_en%0d", i), rd_en, 0);
      tick();
      chk($sformatf("fill_occ%0d", i), occupancy, i + 1);
    end
    chk("fill_full", full, 1);
    chk("fill_empty", empty, 0);
    eof_in = 0;
    #1;
    chk("over_wr_en", wr_en, 0);
    tick();
    chk("over_occ", occupancy, 4);
    chk_drop("over_drop", 1);

    // Drain: rd_addr 0..3, valid one cycle after rd_en, eof on 3rd
    enqueue = 0; ready_in = 1;
    #1;
    chk("drain_rd_en0", rd_en, 1);
    chk("drain_rd_addr0", rd_addr, 0);
    chk("drain_valid_pre", valid_out, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("drain_valid%0d", i), valid_out, 1);
      chk($sformatf("drain_eof%0d", i), eof_out, (i == 3) ? 1 : 0);
      chk($sformatf("drain_occ%0d", i), occupancy, 4 - i);
      if (i < 4) begin
        chk($sformatf("drain_rd_en%0d", i), rd_en, 1);
        chk($sformatf("drain_rd_addr%0d", i), rd_addr, i);
      end
    end
    chk("drain_empty", empty, 1);
    chk("drain_rd_en_end", rd_en, 0);
    tick();
    chk("drain_valid_end", valid_out, 0);

    // Full with simultaneous read: read wins, write dropped
    ready_in = 0; enqueue = 1;
    for (int i = 0; i < 4; i++) tick();
    chk("fr_occ4", occupancy, 4);
    ready_in = 1;
    #1;
    chk("fr_rd_en", rd_en, 1);
    chk("fr_wr_en", wr_en, 0);
    tick();
    chk("fr_occ3", occupancy, 3);
    chk_drop("fr_drop", 2);
    enqueue = 0; ready_in = 0;
    #1;

    // Flush with a read in flight at the flush cycle
    ready_in = 1; flush = 1;
    #1;
    chk("fl_rd_en", rd_en, 1);
    chk("fl_rd_addr", rd_addr, 1);
    tick();
    flush = 0; enqueue = 1;
    #1;
    chk("fl_valid", valid_out, 1);
    chk("fl_rd_blocked", rd_en, 0);
    chk("fl_wr_blocked", wr_en, 0);
    tick();
    enqueue = 0; ready_in = 0;
    #1;
    chk("fl_valid_after", valid_out, 0);
    chk("fl_empty", empty, 1);
    chk("fl_occ", occupancy, 0);
    chk("fl_head", wr_addr, 0);
    chk("fl_tail", rd_addr, 0);
    chk_drop("fl_drop", 2);

    // Streaming wrap: 10 enqueues with ready high, then drain
    vcount = 0; occ_max = 0;
    ready_in = 1;
    for (int i = 0; i < 13; i++) begin
      enqueue = (i < 10);
      #1;
      if (i < 10) begin
        chk($sformatf("st_wr_en%0d", i), wr_en, 1);
        chk($sformatf("st_wr_addr%0d", i), wr_addr, i % 4);
      end
      if (valid_out) vcount++;
      if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
      tick();
    end
    chk("st_valid_count", vcount, 10);
    chk("st_occ_max", occ_max, 1);
    chk("st_empty", empty, 1);
    chk_drop("st_drop", 2);

    // Async reset mid-stream with occupancy 2 and a vector on q_b
    ready_in = 0; enqueue = 1;
    for (int i = 0; i < 3; i++) tick();
    enqueue = 0; ready_in = 1;
    tick();
    ready_in = 0;
    #1;
    chk("ar_occ_pre", occupancy, 2);
    chk("ar_valid_pre", valid_out, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_valid", valid_out, 0);
    chk("ar_eof", eof_out, 0);
    chk("ar_occ", occupancy, 0);
    chk("ar_empty", empty, 1);
    chk("ar_full", full, 0);
    chk("ar_wr_addr", wr_addr, 0);
    chk("ar_rd_addr", rd_addr, 0);
    chk("ar_wr_en", wr_en, 0);
    chk("ar_rd_en", rd_en, 0);
    chk_drop("ar_drop", 0);
    tick();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
